// File: rtl/kugelblitz_pkg.sv
// Shared types for the Kugelblitz patch scheduler: rule record, FSM state and stat width.
package kugelblitz_pkg;

    localparam int STAT_W      = 32;
    // Rule fields are stored at their widest supported size so that one record type serves every parameterisation.
    localparam int RULE_BEAT_W = 16;
    localparam int RULE_OFF_W  = 8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_INFRAME = 1'b1
    } state_t;

    typedef struct packed {
        logic                   enable;
        logic [RULE_BEAT_W-1:0] beat;
        logic [RULE_OFF_W-1:0]  offset;
        logic [7:0]             data;
    } rule_t;

endpackage

// File: rtl/kugelblitz_rule_match.sv
// Combinational priority lookup: the lowest-index enabled rule whose beat equals the given index wins.
module kugelblitz_rule_match
    import kugelblitz_pkg::*;
#(
    parameter int RULE_COUNT = 4
) (
    input  rule_t                  rules [RULE_COUNT],
    input  logic [RULE_BEAT_W-1:0] beat,
    output logic                   hit,
    output logic [RULE_OFF_W-1:0]  offset,
    output logic [7:0]             data
);

    always_comb begin
        hit    = 1'b0;
        offset = '0;
        data   = '0;
        // Scan from the top down so a lower-index match overwrites a higher one.
        for (int i = RULE_COUNT - 1; i >= 0; i--) begin
            if (rules[i].enable && (rules[i].beat == beat)) begin
                hit    = 1'b1;
                offset = rules[i].offset;
                data   = rules[i].data;
            end
        end
    end

endmodule

// File: rtl/kugelblitz_patch_sched.sv
// Frame-synchronous byte-patch scheduler with shadow/active rule tables.
// Optional statistics counters are built when KUGELBLITZ_PATCH_STATS_EN is defined.
module kugelblitz_patch_sched
    import kugelblitz_pkg::*;
#(
    parameter int RULE_COUNT = 4,
    parameter int KEEP_WIDTH = 64,
    parameter int BEAT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_wr_en,
    input  logic [$clog2(RULE_COUNT)-1:0] cfg_wr_idx,
    input  logic [BEAT_WIDTH-1:0]         cfg_wr_beat,
    input  logic [$clog2(KEEP_WIDTH)-1:0] cfg_wr_offset,
    input  logic [7:0]                    cfg_wr_data,
    input  logic                          cfg_wr_enable,
    input  logic                          cfg_commit,
    output logic                          cfg_commit_pending,
    output logic                          cfg_commit_done,
    input  logic                          mon_tvalid,
    input  logic                          mon_tready,
    input  logic                          mon_tlast,
    output logic                          patch_valid,
    output logic [$clog2(KEEP_WIDTH)-1:0] patch_offset,
    output logic [7:0]                    patch_data,
    output logic [31:0]                   stat_frames,
    output logic [31:0]                   stat_patches
);

    localparam int OFF_W = $clog2(KEEP_WIDTH);
    localparam logic [BEAT_WIDTH-1:0] BEAT_MAX = '1;

    state_t                  state;
    logic [BEAT_WIDTH-1:0]   beat_cnt;
    logic [BEAT_WIDTH-1:0]   beat_nxt;
    rule_t                   shadow     [RULE_COUNT];
    rule_t                   active     [RULE_COUNT];
    rule_t                   active_nxt [RULE_COUNT];
    logic                    accepted;
    logic                    last_beat;
    logic                    apply;
    logic                    match_hit;
    logic [RULE_OFF_W-1:0]   match_offset;
    logic [7:0]              match_data;

    always_comb begin
        accepted  = mon_tvalid && mon_tready;
        last_beat = accepted && mon_tlast;
        // Commits land only at a frame boundary so one frame never sees two table versions.
        apply     = (cfg_commit_pending || cfg_commit) &&
                    (((state == ST_IDLE) && !accepted) || last_beat);

        beat_nxt = beat_cnt;
        if (last_beat) begin
            beat_nxt = '0;
        end else if (accepted && (beat_cnt != BEAT_MAX)) begin
            beat_nxt = beat_cnt + 1'b1;
        end

        for (int i = 0; i < RULE_COUNT; i++) begin
            active_nxt[i] = apply ? shadow[i] : active[i];
        end
    end

    // Lookup runs on next-state values so the registered outputs line up with the beat on the bus.
    kugelblitz_rule_match #(
        .RULE_COUNT (RULE_COUNT)
    ) u_match (
        .rules  (active_nxt),
        .beat   (RULE_BEAT_W'(beat_nxt)),
        .hit    (match_hit),
        .offset (match_offset),
        .data   (match_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            beat_cnt           <= '0;
            cfg_commit_pending <= 1'b0;
            cfg_commit_done    <= 1'b0;
            patch_valid        <= 1'b0;
            patch_offset       <= '0;
            patch_data         <= '0;
            for (int i = 0; i < RULE_COUNT; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE:    if (accepted && !mon_tlast) state <= ST_INFRAME;
                ST_INFRAME: if (last_beat) state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase

            beat_cnt           <= beat_nxt;
            cfg_commit_pending <= (cfg_commit_pending || cfg_commit) && !apply;
            cfg_commit_done    <= apply;
            patch_valid        <= match_hit;
            patch_offset       <= match_offset[OFF_W-1:0];
            patch_data         <= match_data;

            for (int i = 0; i < RULE_COUNT; i++) begin
                active[i] <= active_nxt[i];
            end
            // Shadow update is independent of apply; a coinciding commit copies the old contents.
            if (cfg_wr_en) begin
                shadow[cfg_wr_idx] <= '{enable: cfg_wr_enable,
                                        beat:   RULE_BEAT_W'(cfg_wr_beat),
                                        offset: RULE_OFF_W'(cfg_wr_offset),
                                        data:   cfg_wr_data};
            end
        end
    end

`ifdef KUGELBLITZ_PATCH_STATS_EN
    logic [STAT_W-1:0] frames_q;
    logic [STAT_W-1:0] patches_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q  <= '0;
            patches_q <= '0;
        end else begin
            if (last_beat) frames_q <= frames_q + 1'b1;
            if (accepted && patch_valid) patches_q <= patches_q + 1'b1;
        end
    end

    assign stat_frames  = frames_q;
    assign stat_patches = patches_q;
`else
    assign stat_frames  = '0;
    assign stat_patches = '0;
`endif

endmodule
